serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Multi-cycle bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
//   It is the inverse-direction companion to the ripple-carry adders in the arithmetic
//   catalog. It trades latency for a single 1-bit full-subtractor cell plus a borrow flop.
//   The ALU datapath uses it behind a start/done handshake.
// PARAMETERS
//   WIDTH   4   operand/result width in bits; legal range 2..32
// PORTS
//   clk    in   1      rising-edge clock; the only clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; sampled only when accepting (state IDLE or DONE)
//   a      in   WIDTH  minuend; captured on the accepted start cycle
//   b      in   WIDTH  subtrahend; captured on the accepted start cycle
//   bin    in   1      borrow-in; captured on the accepted start cycle
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse; results valid this cycle and held afterwards
//   diff   out  WIDTH  a - b - bin, mod 2^WIDTH
//   bout   out  1      borrow-out; 1 iff unsigned a < b + bin
//   ovf    out  1      two's-complement overflow of the subtraction
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-high (clk, rst).
//   - Reset state:
//     - state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0.
//     - Internal shift registers, borrow flop and bit counter are all cleared.
//   - FSM states: IDLE, RUN, DONE.
//   - IDLE: start=1 -> latch a, b into shift regs; borrow flop <= bin; cnt <= 0; go RUN.
//   - RUN: each cycle computes bit i = cnt from the LSBs of the shift regs.
//     - d  = a_i ^ b_i ^ br
//     - br <= (~a_i & b_i) | (~(a_i ^ b_i) & br)
//     - d is shifted into the MSB of the result register; a and b shift right.
//     - cnt increments. After bit WIDTH-1 is processed, go DONE.
//     - start is ignored in RUN; a, b and bin changes have no effect.
//   - DONE (exactly one cycle):
//     - done=1; diff = result register; bout = final br.
//     - ovf = (a_cap[W-1] ^ b_cap[W-1]) & (diff[W-1] ^ a_cap[W-1]).
//     - The captured MSBs a_cap/b_cap are kept for this computation.
//     - start=1 here is accepted as a new request (back-to-back) -> RUN next cycle.
//     - Otherwise go IDLE.
//   - Latency: start accepted at edge N -> busy=1 for WIDTH cycles -> done=1 in cycle
//     N+WIDTH+1. Throughput is one op per WIDTH+1 cycles.
//   - Output registers diff/bout/ovf update only on DONE entry and hold through IDLE
//     and the next RUN. They never show partial results.
//   - Reset mid-RUN: the operation is aborted; done is never pulsed for it; outputs go
//     to 0 at the next edge.
//   - start and rst in the same cycle: rst wins.
//   - Wrap-around: diff is modulo 2^WIDTH; the borrow is reported only on bout.
// TESTING (WIDTH=4)
//   - 7 - 3, bin=0 -> diff=4'h4, bout=0, ovf=0; done exactly 5 cycles after start.
//   - 3 - 7, bin=0 -> diff=4'hC, bout=1, ovf=0.
//   - 8 - 1, bin=0 (-8 - 1 signed) -> diff=4'h7, bout=0, ovf=1.
//   - 0 - 0, bin=1 -> diff=4'hF, bout=1, ovf=0.
//   - Second start pulsed and a/b changed mid-RUN -> first result unchanged; one done
//     pulse only. Back-to-back start in the DONE cycle -> next done exactly 5 cycles later.
//   - rst asserted at RUN cycle 2 -> busy=0 and outputs 0 next cycle; no done pulse.
//   - Exhaustive random: all a, b, bin compared against a - b - bin.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// behind a start/done handshake. Results are registered and held until the next op completes.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] a_sh_reg;
   logic [WIDTH-1:0] b_sh_reg;
   logic [WIDTH-1:0] res_reg;
   logic             br_reg;
   logic [CW-1:0]    cnt_reg;
   logic             a_msb_reg;
   logic             b_msb_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [WIDTH-1:0] diff_reg;
   logic             bout_reg;
   logic             ovf_reg;

   // Single full-subtractor cell working on the current LSBs.
   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             br_next;
   logic [WIDTH-1:0] res_next;
   logic             last_bit;

   assign a_bit    = a_sh_reg[0];
   assign b_bit    = b_sh_reg[0];
   assign d_bit    = a_bit ^ b_bit ^ br_reg;
   assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);
   assign res_next = {d_bit, res_reg[WIDTH-1:1]};
   assign last_bit = (cnt_reg == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         a_sh_reg  <= '0;
         b_sh_reg  <= '0;
         res_reg   <= '0;
         br_reg    <= 1'b0;
         cnt_reg   <= '0;
         a_msb_reg <= 1'b0;
         b_msb_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         diff_reg  <= '0;
         bout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               done_reg <= 1'b0;
               if (start) begin
                  a_sh_reg  <= a;
                  b_sh_reg  <= b;
                  res_reg   <= '0;
                  br_reg    <= bin;
                  cnt_reg   <= '0;
                  a_msb_reg <= a[WIDTH-1];
                  b_msb_reg <= b[WIDTH-1];
                  busy_reg  <= 1'b1;
                  state_reg <= RUN;
               end else begin
                  state_reg <= IDLE;
               end
            end
            RUN: begin
               a_sh_reg <= a_sh_reg >> 1;
               b_sh_reg <= b_sh_reg >> 1;
               res_reg  <= res_next;
               br_reg   <= br_next;
               cnt_reg  <= cnt_reg + CW'(1);
               if (last_bit) begin
                  // d_bit is the MSB of the finished difference on this edge.
                  diff_reg  <= res_next;
                  bout_reg  <= br_next;
                  ovf_reg   <= (a_msb_reg ^ b_msb_reg) & (d_bit ^ a_msb_reg);
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= DONE;
               end
            end
            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign diff = diff_reg;
   assign bout = bout_reg;
   assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=4,
// including handshake latency, mid-run disturbances and reset abort.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int n_cmp = 0;
   int n_err = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op at the next negedge; returns edges from accept to done and busy cycles seen.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         output int lat, output int nbusy);
      @(negedge clk);
      start = 1'b1; a = av; b = bv; bin = ci;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      lat = 0;
      nbusy = busy ? 1 : 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (busy) nbusy++;
      end
   endtask

   task automatic check_result(input string tag, input int lat, input int nbusy,
                               input logic [W-1:0] ed, input logic eb, input logic eo);
      $display("op %s: diff=%h bout=%b ovf=%b lat=%0d", tag, diff, bout, ovf, lat);
      check({tag, " latency"}, lat, W);
      check({tag, " busy cycles"}, nbusy, W);
      check({tag, " done"}, done, 1'b1);
      check({tag, " diff"}, diff, ed);
      check({tag, " bout"}, bout, eb);
      check({tag, " ovf"}, ovf, eo);
   endtask

   initial begin
      int lat, nb, pulses;
      logic [W-1:0] held;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset diff", diff, 4'h0);
      check("reset bout", bout, 1'b0);
      check("reset ovf", ovf, 1'b0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk);

      // Directed vectors from IDLE
      run_op(4'd7, 4'd3, 1'b0, lat, nb);
      check_result("7-3", lat, nb, 4'h4, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("7-3 done single pulse", done, 1'b0);
      check("7-3 diff held in idle", diff, 4'h4);

      run_op(4'd3, 4'd7, 1'b0, lat, nb);
      check_result("3-7", lat, nb, 4'hC, 1'b1, 1'b0);
      @(posedge clk);

      run_op(4'd8, 4'd1, 1'b0, lat, nb);
      check_result("8-1", lat, nb, 4'h7, 1'b0, 1'b1);
      @(posedge clk);

      run_op(4'd0, 4'd0, 1'b1, lat, nb);
      check_result("0-0-1", lat, nb, 4'hF, 1'b1, 1'b0);

      // Back-to-back: next start issued in the DONE cycle
      run_op(4'd9, 4'd2, 1'b1, lat, nb);
      check_result("b2b 9-2-1", lat, nb, 4'h6, 1'b0, 1'b1);
      run_op(4'd5, 4'd10, 1'b0, lat, nb);
      check_result("b2b 5-10", lat, nb, 4'hB, 1'b1, 1'b1);
      @(posedge clk);

      // Mid-run start pulse and operand changes are ignored
      @(negedge clk);
      start = 1'b1; a = 4'd5; b = 4'd2; bin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("midrun outputs held", diff, 4'hB);
      start = 1'b1; a = 4'hF; b = 4'h0; bin = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      pulses = 0; held = '0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            pulses++;
            held = diff;
         end
         @(posedge clk); #1;
      end
      $display("op midrun 5-2: pulses=%0d diff=%h", pulses, held);
      check("midrun done pulses", pulses, 1);
      check("midrun diff", held, 4'h3);
      check("midrun bout", bout, 1'b0);
      check("midrun busy after", busy, 1'b0);

      // Reset at RUN cycle 2, together with a start request
      @(negedge clk);
      start = 1'b1; a = 4'd12; b = 4'd1; bin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("abort busy before rst", busy, 1'b1);
      rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      check("abort busy", busy, 1'b0);
      check("abort done", done, 1'b0);
      check("abort diff", diff, 4'h0);
      check("abort bout", bout, 1'b0);
      check("abort ovf", ovf, 1'b0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done || busy) pulses++;
      end
      $display("op abort: stray activity=%0d", pulses);
      check("abort no done", pulses, 0);

      // Exhaustive sweep against an arithmetic model
      for (int ci = 0; ci < 2; ci++) begin
         for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
               logic [W:0] wide;
               int sa, sb, sr;
               wide = {1'b0, W'(ai)} - {1'b0, W'(bi)} - (W+1)'(ci);
               sa = (ai >= 8) ? ai - 16 : ai;
               sb = (bi >= 8) ? bi - 16 : bi;
               sr = sa - sb - ci;
               run_op(W'(ai), W'(bi), 1'(ci), lat, nb);
               check_result($sformatf("%0d-%0d-%0d", ai, bi, ci), lat, nb,
                            wide[W-1:0], wide[W], (sr < -8 || sr > 7));
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
